multiciclo_control: RTL and testbench
=====================================

Name: multiciclo_control

Overview:
- Multicycle control unit for the RV32I subset core, directly upstream of the ALU.
- A Moore FSM steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives every datapath enable and mux select.
- It also drives the 5-bit ALU operation code, using the shared OP* constants from Parametros.v (OPADD, OPSUB, OPAND, OPOR, OPSLT, OPNULL).
- The ALU's zero flag is consumed here to qualify branch PC writes.

Parameters:
- RESET_STATE, 4'd0: state entered on reset (FETCH).

Ports:
- iCLK  in  1  system clock, all state updates on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iInstr  in  32  current IR contents; only opcode[6:0], funct3[14:12] and funct7[31:25] are used.
- iZero  in  1  ALU zero flag.
- oIRWrite  out  1  load IR and PCold.
- oPCWrite  out  1  load PC; already qualified by iZero for branches.
- oIorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- oMemRead  out  1  memory read enable.
- oMemWrite  out  1  memory write enable.
- oRegWrite  out  1  register file write enable.
- oMemtoReg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC.
- oALUSrcA  out  2  ALU A select: 00 = PC, 01 = regA, 10 = PCold.
- oALUSrcB  out  2  ALU B select: 00 = regB, 01 = const 4, 10 = imm.
- oALUControl  out  5  OP* code to the ALU.
- oPCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut.
- oState  out  4  current state, for debug.
- oError  out  1  sticky illegal-instruction flag.
- oRetired  out  32  retired-instruction counter.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, ALU_WB=7, BRANCH=8, EXEC_I=9, JAL=10, ERROR=15.
- Reset:
  - On a rising edge with iRST=1: state←FETCH, oError←0, oRetired←0.
  - While iRST=1, all enables (IRWrite, PCWrite, MemRead, MemWrite, RegWrite) are forced to 0.
  - Reset mid-instruction aborts the instruction; no partial writes occur in the reset cycle.
- Default outputs: all enables 0, all selects 00, oALUControl=OPNULL, unless a state below sets them.
- FETCH:
  - IorD=0, MemRead=1, IRWrite=1, ALUSrcA=00, ALUSrcB=01, OPADD, PCSource=00, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=10, ALUSrcB=10, OPADD (ALUOut←PCold+imm).
  - Next state by opcode: 0000011 or 0100011 →MEMADR; 0110011→EXEC_R; 0010011→EXEC_I; 1100011→BRANCH; 1101111→JAL; any other→ERROR.
- MEMADR:
  - ALUSrcA=01, ALUSrcB=10, OPADD.
  - Next state: MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: IorD=1, MemRead=1 → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=01 → FETCH.
- MEMWRITE: IorD=1, MemWrite=1 → FETCH.
- EXEC_R:
  - ALUSrcA=01, ALUSrcB=00.
  - Op decode: funct3/funct7 000/0000000→OPADD; 000/0100000→OPSUB; 111/0→OPAND; 110/0→OPOR; 010/0→OPSLT.
  - Next state: ALU_WB for the combinations above; any other combination→ERROR.
- EXEC_I:
  - ALUSrcA=01, ALUSrcB=10.
  - Op decode by funct3: 000→OPADD; 010→OPSLT; 111→OPAND; 110→OPOR.
  - Next state: ALU_WB for the funct3 values above; any other→ERROR.
- ALU_WB: RegWrite=1, MemtoReg=00 → FETCH.
- BRANCH:
  - Only funct3=000 (beq) is legal; any other funct3→ERROR with no PC write.
  - ALUSrcA=01, ALUSrcB=00, OPSUB, PCSource=01, oPCWrite=iZero.
  - Next state: FETCH.
- JAL: RegWrite=1, MemtoReg=10, PCSource=01, PCWrite=1 → FETCH.
- ERROR: all enables 0, oError=1, remains in ERROR until reset.
- oRetired:
  - Increments by 1 on the edge leaving MEMWB, MEMWRITE, ALU_WB, BRANCH or JAL.
  - Wraps modulo 2^32.
  - Does not count ERROR.
- Latencies (FETCH to FETCH): lw 5 cycles; sw, R-type, I-type ALU 4 cycles; beq and jal 3 cycles.
- Outputs are combinational from state and iInstr; iInstr is stable after FETCH because IRWrite is asserted only in FETCH.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3): states 0→1→6→7→0; OPADD in state 6; RegWrite=1 only in state 7; oRetired=1.
- lw (0x0000A183): states 0→1→2→3→4→0; IorD=1 in states 3/4; MemtoReg=01 with RegWrite in state 4; sw (0x0030A023) takes 0→1→2→5→0 with MemWrite=1 only in state 5.
- beq (0x00208463): with iZero=1 in BRANCH → oPCWrite=1 and PCSource=01; with iZero=0 → oPCWrite=0; both return to FETCH and increment oRetired.
- sub (0x402081B3) → OPSUB; slti (0x0050A193) → OPSLT; jal (0x008000EF) → MemtoReg=10, PCWrite=1 in state 10.
- Illegal opcode 0x0000007F, then R-type with funct7=0000001 → ERROR, oError=1, no enables asserted, state held 100 cycles, oRetired unchanged; iRST=1 clears to FETCH with oError=0.
- iRST asserted in MEMREAD → no enables during the reset cycle; state=FETCH next cycle; oRetired=0.

Source files
------------

// File: rtl/multiciclo_control.sv
// Multicycle control unit for the RV32I subset core.
// A Moore FSM walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB and
// drives every datapath enable and mux select plus the ALU operation code.
// Ports:
//   iCLK, iRST      clock, synchronous active-high reset
//   iInstr[31:0]    IR contents (opcode, funct3, funct7 used)
//   iZero           ALU zero flag, qualifies the beq PC write
//   oIRWrite, oPCWrite, oIorD, oMemRead, oMemWrite, oRegWrite  enables/selects
//   oMemtoReg, oALUSrcA, oALUSrcB, oPCSource [1:0]  datapath mux selects
//   oALUControl[4:0] OP* code to the ALU
//   oState[3:0]     current state (debug)
//   oError          sticky illegal-instruction flag
//   oRetired[31:0]  retired-instruction counter
module multiciclo_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  input  logic        iZero,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oIorD,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oRegWrite,
  output logic [1:0]  oMemtoReg,
  output logic [1:0]  oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic [4:0]  oALUControl,
  output logic [1:0]  oPCSource,
  output logic [3:0]  oState,
  output logic        oError,
  output logic [31:0] oRetired
);

  // ALU operation codes shared with the ALU (Parametros.v values)
  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPOR   = 5'd1;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPNULL = 5'd31;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic        error_q;
  logic [31:0] retired_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;

  assign opcode       = iInstr[6:0];
  assign funct3       = iInstr[14:12];
  assign funct7       = iInstr[31:25];
  assign unused_instr = ^{iInstr[24:15], iInstr[11:7]};

  // Function decode for R-type and I-type ALU instructions
  logic [4:0] r_op, i_op;
  logic       r_ok, i_ok, beq_ok;

  always_comb begin
    r_op = OPNULL;
    r_ok = 1'b1;
    unique case ({funct7, funct3})
      {7'b0000000, 3'b000}: r_op = OPADD;
      {7'b0100000, 3'b000}: r_op = OPSUB;
      {7'b0000000, 3'b111}: r_op = OPAND;
      {7'b0000000, 3'b110}: r_op = OPOR;
      {7'b0000000, 3'b010}: r_op = OPSLT;
      default:              r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = OPNULL;
    i_ok = 1'b1;
    case (funct3)
      3'b000:  i_op = OPADD;
      3'b010:  i_op = OPSLT;
      3'b111:  i_op = OPAND;
      3'b110:  i_op = OPOR;
      default: i_ok = 1'b0;
    endcase
  end

  assign beq_ok = (funct3 == 3'b000);

  // Ungated enables; the reset gate is applied at the ports
  logic ir_wr, pc_wr, mem_rd, mem_wr, reg_wr;

  always_comb begin
    state_d     = state_q;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_wr      = 1'b0;
    oIorD       = 1'b0;
    oMemtoReg   = 2'b00;
    oALUSrcA    = 2'b00;
    oALUSrcB    = 2'b00;
    oALUControl = OPNULL;
    oPCSource   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd      = 1'b1;
        ir_wr       = 1'b1;
        oALUSrcB    = 2'b01;
        oALUControl = OPADD;
        pc_wr       = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        oALUSrcA    = 2'b10;
        oALUSrcB    = 2'b10;
        oALUControl = OPADD;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_RTYPE:           state_d = S_EXEC_R;
          OPC_ITYPE:           state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          default:             state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        oALUSrcA    = 2'b01;
        oALUSrcB    = 2'b10;
        oALUControl = OPADD;
        state_d     = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        oIorD   = 1'b1;
        mem_rd  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr    = 1'b1;
        oMemtoReg = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        oIorD   = 1'b1;
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_R: begin
        oALUSrcA    = 2'b01;
        oALUSrcB    = 2'b00;
        oALUControl = r_op;
        state_d     = r_ok ? S_ALU_WB : S_ERROR;
      end
      S_EXEC_I: begin
        oALUSrcA    = 2'b01;
        oALUSrcB    = 2'b10;
        oALUControl = i_op;
        state_d     = i_ok ? S_ALU_WB : S_ERROR;
      end
      S_ALU_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        oALUSrcA    = 2'b01;
        oALUSrcB    = 2'b00;
        oALUControl = OPSUB;
        oPCSource   = 2'b01;
        // Illegal branch funct3 must not touch the PC on its way to ERROR
        pc_wr       = iZero & beq_ok;
        state_d     = beq_ok ? S_FETCH : S_ERROR;
      end
      S_JAL: begin
        reg_wr    = 1'b1;
        oMemtoReg = 2'b10;
        oPCSource = 2'b01;
        pc_wr     = 1'b1;
        state_d   = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // An instruction retires on the edge that leaves its final state
  logic retire;
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALU_WB) || (state_q == S_JAL) ||
                  ((state_q == S_BRANCH) && beq_ok);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= state_t'(RESET_STATE);
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ERROR) error_q <= 1'b1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign oIRWrite  = ir_wr  & ~iRST;
  assign oPCWrite  = pc_wr  & ~iRST;
  assign oMemRead  = mem_rd & ~iRST;
  assign oMemWrite = mem_wr & ~iRST;
  assign oRegWrite = reg_wr & ~iRST;
  assign oState    = state_q;
  assign oError    = error_q;
  assign oRetired  = retired_q;

endmodule

// File: tb/tb_multiciclo_control.sv
module tb_multiciclo_control;

  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPOR   = 5'd1;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPNULL = 5'd31;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iInstr;
  logic        iZero;
  logic        oIRWrite, oPCWrite, oIorD, oMemRead, oMemWrite, oRegWrite;
  logic [1:0]  oMemtoReg, oALUSrcA, oALUSrcB, oPCSource;
  logic [4:0]  oALUControl;
  logic [3:0]  oState;
  logic        oError;
  logic [31:0] oRetired;

  multiciclo_control #(.RESET_STATE(4'd0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr), .iZero(iZero),
    .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oIorD(oIorD),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRegWrite(oRegWrite),
    .oMemtoReg(oMemtoReg), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
    .oALUControl(oALUControl), .oPCSource(oPCSource), .oState(oState),
    .oError(oError), .oRetired(oRetired)
  );

  always #5 iCLK = ~iCLK;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_ret;
  int          path[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the sequence of states an instruction visits, by instruction class
  task automatic model_path(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    path = {0, 1};
    case (opc)
      7'b0000011: path = {path, 2, 3, 4};
      7'b0100011: path = {path, 2, 5};
      7'b0110011: begin
        ok = (f7 == 7'd0 && f3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
             (f7 == 7'b0100000 && f3 == 3'b000);
        path = {path, 6, ok ? 7 : 15};
      end
      7'b0010011: path = {path, 9, (f3 inside {3'b000, 3'b010, 3'b111, 3'b110}) ? 7 : 15};
      7'b1100011: path = (f3 == 3'b000) ? {path, 8} : {path, 8, 15};
      7'b1101111: path = {path, 10};
      default:    path = {path, 15};
    endcase
  endtask

  function automatic logic [4:0] r_alu(input logic [31:0] ins);
    if (ins[31:25] == 7'b0100000) return OPSUB;
    case (ins[14:12])
      3'b000: return OPADD;
      3'b111: return OPAND;
      3'b110: return OPOR;
      default: return OPSLT;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [31:0] ins);
    case (ins[14:12])
      3'b000: return OPADD;
      3'b111: return OPAND;
      3'b110: return OPOR;
      default: return OPSLT;
    endcase
  endfunction

  // Expected {IRWrite,PCWrite,MemRead,MemWrite,RegWrite} per state
  function automatic logic [4:0] exp_en(input int s, input logic [31:0] ins, input logic z);
    case (s)
      0:  return 5'b11100;
      3:  return 5'b00100;
      4:  return 5'b00001;
      5:  return 5'b00010;
      7:  return 5'b00001;
      8:  return {1'b0, z && ins[14:12] == 3'b000, 3'b000};
      10: return 5'b01001;
      default: return 5'b00000;
    endcase
  endfunction

  // Expected {IorD,MemtoReg,ALUSrcA,ALUSrcB,PCSource,ALUControl} per state
  function automatic logic [13:0] exp_sel(input int s, input logic [31:0] ins);
    case (s)
      0:  return {1'b0, 2'b00, 2'b00, 2'b01, 2'b00, OPADD};
      1:  return {1'b0, 2'b00, 2'b10, 2'b10, 2'b00, OPADD};
      2:  return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00, OPADD};
      3:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL};
      4:  return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00, OPNULL};
      5:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL};
      6:  return {1'b0, 2'b00, 2'b01, 2'b00, 2'b00, r_alu(ins)};
      8:  return {1'b0, 2'b00, 2'b01, 2'b00, 2'b01, OPSUB};
      9:  return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00, i_alu(ins)};
      10: return {1'b0, 2'b10, 2'b00, 2'b00, 2'b01, OPNULL};
      default: return {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, OPNULL};
    endcase
  endfunction

  function automatic logic [4:0] dut_en();
    return {oIRWrite, oPCWrite, oMemRead, oMemWrite, oRegWrite};
  endfunction

  function automatic logic [13:0] dut_sel();
    return {oIorD, oMemtoReg, oALUSrcA, oALUSrcB, oPCSource, oALUControl};
  endfunction

  task automatic do_reset();
    iRST = 1'b1;
    @(negedge iCLK);
    check("enables_in_reset", {27'd0, dut_en()}, 32'd0);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    exp_ret = '0;
    check("state_after_reset", {28'd0, oState}, 32'd0);
    check("error_after_reset", {31'd0, oError}, 32'd0);
    check("retired_after_reset", oRetired, 32'd0);
  endtask

  // zmode: 0/1 force iZero, 2 random; rst_at: path index at which to reset, -1 none
  task automatic run(input logic [31:0] ins, input int zmode, input int rst_at);
    bool_t: begin end
    model_path(ins);
    iInstr = ins;
    for (int k = 0; k < path.size(); k++) begin
      if (k == rst_at) begin
        do_reset();
        return;
      end
      iZero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge iCLK);
      check($sformatf("state[%0d] ins=%h", k, ins), {28'd0, oState}, path[k]);
      check($sformatf("enables s%0d ins=%h", path[k], ins), {27'd0, dut_en()},
            {27'd0, exp_en(path[k], ins, iZero)});
      // selects of an exec state whose function is illegal are unspecified
      if (!(path[path.size()-1] == 15 && path[k] inside {6, 8, 9}))
        check($sformatf("selects s%0d ins=%h", path[k], ins), {18'd0, dut_sel()},
              {18'd0, exp_sel(path[k], ins)});
      check("retired", oRetired, exp_ret);
      check("error_flag", {31'd0, oError}, {31'd0, path[k] == 15});
      @(posedge iCLK); #1;
    end
    if (path[path.size()-1] == 15) begin
      for (int c = 0; c < 100; c++) begin
        iZero = 1'($urandom_range(0, 1));
        @(negedge iCLK);
        check("error_hold_state", {28'd0, oState}, 32'd15);
        check("error_hold_enables", {27'd0, dut_en()}, 32'd0);
        check("error_hold_flag", {31'd0, oError}, 32'd1);
        check("error_hold_retired", oRetired, exp_ret);
        @(posedge iCLK); #1;
      end
      do_reset();
    end else begin
      exp_ret = exp_ret + 32'd1;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0]  f3s [4];
    int          kind;
    r = $urandom;
    f3s = '{3'b000, 3'b010, 3'b111, 3'b110};
    kind = $urandom_range(0, 19);
    if (kind <= 2)       r[6:0] = 7'b0000011;
    else if (kind <= 4)  r[6:0] = 7'b0100011;
    else if (kind <= 7) begin
      r[6:0] = 7'b0110011;
      case ($urandom_range(0, 4))
        0: {r[31:25], r[14:12]} = {7'b0000000, 3'b000};
        1: {r[31:25], r[14:12]} = {7'b0100000, 3'b000};
        2: {r[31:25], r[14:12]} = {7'b0000000, 3'b111};
        3: {r[31:25], r[14:12]} = {7'b0000000, 3'b110};
        default: {r[31:25], r[14:12]} = {7'b0000000, 3'b010};
      endcase
    end
    else if (kind == 8)  r[6:0] = 7'b0110011;
    else if (kind <= 11) begin
      r[6:0] = 7'b0010011;
      r[14:12] = f3s[$urandom_range(0, 3)];
    end
    else if (kind == 12) r[6:0] = 7'b0010011;
    else if (kind <= 15) begin
      r[6:0] = 7'b1100011;
      r[14:12] = 3'b000;
    end
    else if (kind == 16) r[6:0] = 7'b1100011;
    else if (kind <= 18) r[6:0] = 7'b1101111;
    return r;
  endfunction

  initial begin
    logic [31:0] ins;
    int          ra;
    iRST = 1'b1; iInstr = '0; iZero = 1'b0; exp_ret = '0;
    do_reset();

    run(32'h002081B3, 2, -1);   // add
    check("retired_after_add", oRetired, 32'd1);
    run(32'h0000A183, 2, -1);   // lw
    run(32'h0030A023, 2, -1);   // sw
    run(32'h00208463, 1, -1);   // beq taken
    run(32'h00208463, 0, -1);   // beq not taken
    run(32'h402081B3, 2, -1);   // sub
    run(32'h0050A193, 2, -1);   // slti
    run(32'h008000EF, 2, -1);   // jal
    check("retired_after_directed", oRetired, 32'd8);
    run(32'h0000A183, 2, 3);    // reset while in MEMREAD
    run(32'h0000007F, 2, -1);   // illegal opcode
    run(32'h022081B3, 2, -1);   // R-type funct7=0000001
    run(32'h00209463, 1, -1);   // branch with funct3=001

    for (int n = 0; n < 250; n++) begin
      ins = gen_instr();
      model_path(ins);
      ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, path.size() - 1)) : -1;
      run(ins, 2, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
